input_skew_buffer: RTL and testbench

Input-side feeder for the systolic array and the counterpart of the output buffer. It accepts one tile of operand rows, one full row of ARRAYWIDTH lanes per handshake, and stores up to DEPTH rows. On start it replays the tile into the array's edge with the diagonal skew the array needs: lane i lags lane 0 by i cycles. Idle lanes are driven with zeros so the PEs' multiply-accumulate is unaffected.

---
 rtl/input_skew_buffer_if.sv | 26 ++
 rtl/input_skew_buffer.sv | 129 ++++++++++++
 tb/tb_input_skew_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/input_skew_buffer_if.sv
// Row-load handshake and skewed-lane output bundle for input_skew_buffer.
// The producer/testbench side uses master; the buffer itself uses slave.
interface input_skew_buffer_if #(
    parameter int ARRAYWIDTH = 4,
    parameter int DATASIZE   = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [ARRAYWIDTH*DATASIZE-1:0] in_data;
    logic                           in_last;
    logic                           start;
    logic [ARRAYWIDTH-1:0]          out_valid;
    logic [ARRAYWIDTH*DATASIZE-1:0] out_data;
    logic                           busy;
    logic                           done;

    modport master (
        output in_valid, in_data, in_last, start,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_last, start,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/input_skew_buffer.sv
// Stores one tile of operand rows and replays it into the systolic array edge
// with lane i delayed by i cycles; idle lanes carry zero.
module input_skew_buffer #(
    parameter int ARRAYWIDTH = 4,
    parameter int DATASIZE   = 8,
    parameter int DEPTH      = 4
) (
    input logic                clk,
    input logic                rst,
    input_skew_buffer_if.slave bus
);
    localparam int ROWW = ARRAYWIDTH * DATASIZE;
    localparam int KW   = $clog2(DEPTH + 1);
    localparam int TW   = $clog2(DEPTH + ARRAYWIDTH);
    localparam int RW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, READY, FEED} state_e;

    state_e                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [TW-1:0]         t_q, t_d;
    logic [ROWW-1:0]       rows_q [DEPTH];
    logic [ROWW-1:0]       rows_d [DEPTH];
    logic [ARRAYWIDTH-1:0] out_valid_q, out_valid_d;
    logic [ROWW-1:0]       out_data_q, out_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  in_ready;
    logic                  accept;
    logic                  close_tile;
    logic [KW-1:0]         k_inc;
    logic [TW-1:0]         t_end;

    assign in_ready   = ((state_q == IDLE) || (state_q == LOAD)) && (k_q < KW'(DEPTH));
    assign accept     = bus.in_valid && in_ready;
    assign k_inc      = k_q + KW'(accept);
    assign close_tile = accept && (bus.in_last || (k_inc == KW'(DEPTH)));
    // FEED spends T = K+W-1 cycles on data beats plus one closing cycle that emits done.
    assign t_end      = TW'(k_q) + TW'(ARRAYWIDTH - 1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        k_d         = k_inc;
        t_d         = t_q;
        rows_d      = rows_q;
        out_valid_d = '0;
        out_data_d  = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        if (accept) begin
            rows_d[RW'(k_q)] = bus.in_data;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = close_tile ? READY : LOAD;
                end
            end
            LOAD: begin
                // A row accepted alongside start joins the tile; K >= 1 is guaranteed here.
                if (bus.start) begin
                    state_d = FEED;
                end else if (close_tile) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (bus.start) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (t_q == t_end) begin
                    state_d = IDLE;
                    k_d     = '0;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d    = t_q + TW'(1);
                    busy_d = 1'b1;
                    for (int i = 0; i < ARRAYWIDTH; i++) begin
                        if ((t_q >= TW'(i)) && ((t_q - TW'(i)) < TW'(k_q))) begin
                            out_valid_d[i] = 1'b1;
                            out_data_d[i*DATASIZE +: DATASIZE] =
                                rows_q[RW'(t_q - TW'(i))][i*DATASIZE +: DATASIZE];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking belongs in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            t_q         <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // NOTE: row storage has no reset; only slots below K are ever read, so stale rows never leak.
    always_ff @(posedge clk) begin
        rows_q <= rows_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_input_skew_buffer.sv
// Self-checking bench for input_skew_buffer: directed scenarios then randomized tiles,
// checked against a tile-queue reference model.
`timescale 1ns/1ps
module tb_input_skew_buffer;
    localparam int W    = 4;
    localparam int DS   = 8;
    localparam int D    = 4;
    localparam int ROWW = W * DS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_skew_buffer_if #(.ARRAYWIDTH(W), .DATASIZE(DS)) bus ();

    input_skew_buffer #(.ARRAYWIDTH(W), .DATASIZE(DS), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: rows accepted so far for the current tile, and whether it is closed.
    logic [ROWW-1:0] tile[$];
    bit              closed;

    bit              go, v, l, s;
    logic [ROWW-1:0] d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROWW-1:0] pat_row(input int r);
        logic [ROWW-1:0] x;
        for (int i = 0; i < W; i++) x[i*DS +: DS] = 8'(16 * r + i);
        return x;
    endfunction

    task automatic clear_model();
        tile.delete();
        closed = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.start    = 1'b1;
        bus.in_last  = 1'b0;
        bus.in_data  = $urandom;
        repeat (2) begin
            step();
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_data", bus.out_data, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        clear_model();
        check("rst_in_ready", bus.in_ready, 1);
    endtask

    // One clock of load-side stimulus; reports whether the model expects FEED to begin.
    task automatic drive(input bit iv, input logic [ROWW-1:0] id, input bit il, input bit is,
                         output bit started);
        int k_before;
        bit exp_ready;
        k_before     = tile.size();
        exp_ready    = !closed && (k_before < D);
        bus.in_valid = iv;
        bus.in_data  = id;
        bus.in_last  = il;
        bus.start    = is;
        check("in_ready", bus.in_ready, exp_ready);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.start    = 1'b0;
        if (iv && exp_ready) begin
            tile.push_back(id);
            if (il || tile.size() == D) closed = 1'b1;
        end
        started = is && (k_before >= 1);
        check("load_busy", bus.busy, 0);
        check("load_out_valid", bus.out_valid, 0);
        check("load_out_data", bus.out_data, 0);
        check("load_done", bus.done, 0);
    endtask

    // Called right after the edge that sampled start; abort_t >= 0 resets at that FEED cycle.
    task automatic run_feed(input int abort_t);
        int              k, t_total;
        logic [W-1:0]    ev;
        logic [ROWW-1:0] ed, row;
        k       = tile.size();
        t_total = k + W - 1;
        for (int t = 0; t < t_total; t++) begin
            if (t == abort_t) begin
                rst = 1'b1;
                step();
                check("abort_out_valid", bus.out_valid, 0);
                check("abort_out_data", bus.out_data, 0);
                check("abort_busy", bus.busy, 0);
                check("abort_done", bus.done, 0);
                rst = 1'b0;
                check("abort_in_ready", bus.in_ready, 1);
                clear_model();
                return;
            end
            step();
            ev = '0;
            ed = '0;
            for (int i = 0; i < W; i++) begin
                if ((t - i >= 0) && (t - i < k)) begin
                    row = tile[t - i];
                    ev[i] = 1'b1;
                    ed[i*DS +: DS] = row[i*DS +: DS];
                end
            end
            check("beat_valid", bus.out_valid, ev);
            check("beat_data", bus.out_data, ed);
            check("beat_busy", bus.busy, 1);
            check("beat_done", bus.done, 0);
        end
        step();
        check("end_done", bus.done, 1);
        check("end_busy", bus.busy, 0);
        check("end_out_valid", bus.out_valid, 0);
        check("end_out_data", bus.out_data, 0);
        check("end_in_ready", bus.in_ready, 1);
        clear_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.start    = 1'b0;
        clear_model();

        // Reset with start and in_valid held high.
        do_reset();

        // start while empty is ignored.
        drive(1'b0, '0, 1'b0, 1'b1, go);
        drive(1'b0, '0, 1'b0, 1'b0, go);

        // Full tile with in_last on row 3, then start.
        for (int r = 0; r < 4; r++) drive(1'b1, pat_row(r), (r == 3), 1'b0, go);
        drive(1'b0, '0, 1'b0, 1'b1, go);
        if (go) run_feed(-1);

        // Short tile of two rows, loaded back-to-back in the done cycle.
        drive(1'b1, pat_row(5), 1'b0, 1'b0, go);
        drive(1'b1, pat_row(6), 1'b1, 1'b0, go);
        drive(1'b0, '0, 1'b0, 1'b1, go);
        if (go) run_feed(-1);

        // Overflow: six rows offered with no in_last; only four are kept.
        for (int r = 0; r < 6; r++) drive(1'b1, pat_row(r), 1'b0, 1'b0, go);
        drive(1'b0, '0, 1'b0, 1'b1, go);
        if (go) run_feed(-1);

        // start together with the second accept (in_last=0) feeds a 2-row tile.
        drive(1'b1, pat_row(7), 1'b0, 1'b0, go);
        drive(1'b1, pat_row(8), 1'b0, 1'b1, go);
        if (go) run_feed(-1);

        // start together with an in_last row.
        drive(1'b1, pat_row(9), 1'b0, 1'b0, go);
        drive(1'b1, pat_row(10), 1'b1, 1'b1, go);
        if (go) run_feed(-1);

        // Reset at FEED t=2, then a fresh 1-row tile.
        for (int r = 0; r < 3; r++) drive(1'b1, pat_row(r + 11), (r == 2), 1'b0, go);
        drive(1'b0, '0, 1'b0, 1'b1, go);
        if (go) run_feed(2);
        drive(1'b1, pat_row(14), 1'b1, 1'b0, go);
        drive(1'b0, '0, 1'b0, 1'b1, go);
        if (go) run_feed(-1);

        // Randomized tiles with gaps, random in_last and random start.
        for (int n = 0; n < 25; n++) begin
            go = 1'b0;
            for (int c = 0; c < 40 && !go; c++) begin
                v = ($urandom_range(0, 3) != 0);
                l = ($urandom_range(0, 3) == 0);
                s = ($urandom_range(0, 4) == 0);
                d = $urandom;
                drive(v, d, l, s, go);
            end
            if (go) run_feed(-1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
